// File: rtl/sort_stream_ctrl_pkg.sv
// Shared constants and FSM encoding for the sort stream controller.
package sort_stream_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int MAX_N  = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARM   = 3'd2,
        SORT  = 3'd3,
        CLEAR = 3'd4,
        READ  = 3'd5,
        CAPT  = 3'd6,
        HOLD  = 3'd7
    } sortState_t;

endpackage

// File: rtl/sort_stream_ctrl.sv
// Streams a frame into an external sort core, starts it, then drains the
// sorted FIFO one word at a time onto a valid/ready output.
module sort_stream_ctrl #(
    parameter int DATA_W = sort_stream_ctrl_pkg::DATA_W,
    parameter int ADDR_W = sort_stream_ctrl_pkg::ADDR_W,
    parameter int MAX_N  = sort_stream_ctrl_pkg::MAX_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              core_wr_en,
    output logic [ADDR_W-1:0] core_addr,
    output logic [DATA_W-1:0] core_wdata,
    output logic              core_start,
    output logic              core_rd_en,
    input  logic [DATA_W-1:0] core_rdata,
    input  logic              core_done,
    output logic              busy,
    output logic              overflow
);
    import sort_stream_ctrl_pkg::*;

    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAX_N - 1);

    sortState_t        state, stateNext;
    logic [ADDR_W:0]   count;      // words written this frame
    logic [ADDR_W:0]   remaining;  // words still to be delivered
    logic [ADDR_W-1:0] lastAddr;

    assign lastAddr = ADDR_W'(count - CNT_ONE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic; a single-word frame bypasses the core entirely.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (s_valid) stateNext = s_last ? HOLD : LOAD;
            LOAD:  if (s_valid && (s_last || count == LAST_IDX)) stateNext = ARM;
            ARM:   stateNext = SORT;
            SORT:  if (core_done) stateNext = CLEAR;
            CLEAR: stateNext = READ;
            READ:  stateNext = CAPT;
            CAPT:  stateNext = HOLD;
            HOLD:  if (m_ready) stateNext = m_last ? IDLE : READ;
            default: stateNext = IDLE;
        endcase
    end

    // Frame counters, overflow flag and the registered output word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (s_valid) begin
                    overflow <= 1'b0;
                    if (s_last) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        m_last  <= 1'b1;
                        count   <= '0;
                    end else begin
                        count   <= CNT_ONE;
                    end
                end
                LOAD: if (s_valid) begin
                    count <= count + CNT_ONE;
                    // Only a frame cut short by the size limit is flagged.
                    if (!s_last && count == LAST_IDX) overflow <= 1'b1;
                end
                CLEAR: remaining <= count;
                CAPT: begin
                    m_data  <= core_rdata;
                    m_valid <= 1'b1;
                    m_last  <= (remaining == CNT_ONE);
                end
                HOLD: if (m_ready) begin
                    m_valid   <= 1'b0;
                    m_last    <= 1'b0;
                    remaining <= remaining - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Core handshake and input ready; forced quiet while reset is held.
    always_comb begin
        s_ready    = 1'b0;
        core_wr_en = 1'b0;
        core_addr  = '0;
        core_start = 1'b0;
        core_rd_en = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    s_ready    = 1'b1;
                    core_wr_en = s_valid && !s_last;
                end
                LOAD: begin
                    s_ready    = 1'b1;
                    core_wr_en = s_valid;
                    core_addr  = count[ADDR_W-1:0];
                end
                ARM:  core_addr = lastAddr;
                SORT: begin
                    core_start = 1'b1;
                    core_addr  = lastAddr;
                end
                READ: core_rd_en = 1'b1;
                default: ;
            endcase
        end
        core_wdata = core_wr_en ? s_data : '0;
        busy       = reset && (state != IDLE);
    end

endmodule

// File: doc/sort_stream_ctrl.md
SORT_STREAM_CTRL -- requirements
Module: sort_stream_ctrl

Interface
REQ-001 Parameters: DATA_W, default 32, word width; ADDR_W, default 10, sort-core address width; MAX_N, default 2**ADDR_W, maximum words per frame.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 s_data  input  DATA_W  unsorted input word.
REQ-005 s_valid, s_last  input  1 each  input-word valid; input word is the final word of the frame.
REQ-006 s_ready  output  1  input word accepted on a cycle where s_valid and s_ready are both high.
REQ-007 m_data  output  DATA_W  sorted output word.
REQ-008 m_valid, m_last  output  1 each  output-word valid; output word is the final word of the frame.
REQ-009 m_ready  input  1  downstream accepts the output word.
REQ-010 core_wr_en  output  1  sort-core PS port-A write enable.
REQ-011 core_addr  output  ADDR_W  sort-core PS address.
REQ-012 core_wdata  output  DATA_W  sort-core PS write data.
REQ-013 core_start  output  1  sort-core start.
REQ-014 core_rd_en  output  1  sort-core output-FIFO read enable.
REQ-015 core_rdata  input  DATA_W  sort-core FIFO data; valid 1 cycle after core_rd_en.
REQ-016 core_done  input  1  sort-core done.
REQ-017 busy, overflow  output  1 each  busy is high when the FSM is not in IDLE; overflow is a sticky frame-truncation flag.

Function
REQ-018 FSM states: IDLE, LOAD, ARM, SORT, CLEAR, READ, CAPT, HOLD.
- IDLE: s_ready=1.
- The first accepted word goes to LOAD.
- If that word also has s_last, it skips the core: m_data is loaded, m_valid=1, m_last=1, and the FSM goes to HOLD.
REQ-019 LOAD: s_ready=1.
- Each accepted word drives core_wr_en=1, core_addr=count, core_wdata=s_data combinationally in the accept cycle.
- count increments; the first word is written to address 0.
REQ-020 LOAD exit:
- An accepted word with s_last goes to ARM.
- The MAX_N-th accepted word is treated as last, sets overflow, and goes to ARM.
REQ-021 ARM: one cycle with s_ready=0, core_wr_en=0, core_start=0, core_addr=N-1 (N = words in the frame).
REQ-022 SORT:
- Outputs: core_start=1, core_wr_en=0, core_addr=N-1, all held stable.
- Exit: goes to CLEAR on the first cycle core_done=1.
REQ-023 CLEAR: one cycle with core_start=0 and core_wr_en=0, so the core returns to its idle state; then goes to READ with remaining=N.
REQ-024 READ: core_rd_en=1 for exactly one cycle, then goes to CAPT.
REQ-025 CAPT: registers core_rdata into m_data, sets m_valid=1, sets m_last=(remaining==1), then goes to HOLD.
REQ-026 HOLD: m_valid and m_data are held until m_ready.
- On acceptance, m_valid drops and remaining decrements.
- The next state is READ, or IDLE when the accepted word had m_last.
REQ-027 Output throughput is 1 word per 3 cycles when m_ready is held high. Input throughput is 1 word per cycle.
REQ-028 Invariants:
- core_wr_en and core_start are never high in the same cycle.
- core_rd_en is never high outside READ.
- s_ready=0 in every state other than IDLE and LOAD.
REQ-029 overflow clears on the first accepted word of the next frame. count is ADDR_W+1 bits wide, so MAX_N is representable.
REQ-030 core_done high outside SORT is ignored.

Reset
REQ-031 While reset is low, all outputs are 0, except core_addr=0; state=IDLE; count, remaining and overflow are 0.
REQ-032 If reset is asserted mid-frame, the partial frame is discarded with no output. The integrator also holds the sort core in reset for the same interval.
REQ-033 Reset deassertion is synchronised externally; the first active edge after deassertion is in IDLE.

Structure
REQ-034 The shared package holds DATA_W, ADDR_W, MAX_N and the FSM state encoding (3-bit enumeration).
REQ-035 The module is a single module with no sub-modules. The sort core is instantiated beside it at the integration level, not inside it.

Verification
REQ-036 Bench instantiates sort_stream_ctrl plus the existing sort core (BRAM/FIFO models), with clk at 100 MHz.
REQ-037 Frame [5,3,9,1] with s_last on 1 -> writes at addresses 0..3 -> start with core_addr=3 -> output 1,3,5,9 with m_last on 9 only.
REQ-038 Single word 0x7 with s_last -> core_start never rises -> m_data=0x7, m_valid=1, m_last=1.
REQ-039 1025-word frame with no s_last -> overflow=1 after the 1024th word, s_ready=0 from ARM onward, 1024 ascending words out; the next frame clears overflow.
REQ-040 Frame [2,1] with m_ready low for 10 cycles in HOLD -> m_data stays 1 and stable, and no core_rd_en pulse until acceptance.
REQ-041 reset asserted in SORT -> all outputs 0 asynchronously. A new frame [4,2] after release -> output 2,4.
